// File: rtl/wb_excp_ctrl.sv
// wb_excp_ctrl
//   Writeback-stage commit and exception controller. Holds the final pipeline
//   register, commits GPR/CSR writes, prioritises interrupts and exceptions,
//   pulses excp_flush/ertn_flush with the exception payload and then holds a
//   fetch-redirect request until fetch accepts it.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   ms_*                       MEM-stage instruction and its payload
//   ws_allowin                 WB can accept a new instruction
//   rf_we/rf_waddr/rf_wdata    GPR write port
//   rd_addr / rd_data          CSR read address / old CSR value
//   has_int, eentry_out, era_out  status from the CSR file
//   csr_wr_en/wr_addr/wr_data  CSR write port
//   excp_flush, ertn_flush     one-cycle flush pulses
//   era_in, ecode_in, esubcode_in, bad_va_in, va_error_in  exception payload
//   redirect_valid/target/ready  fetch redirect handshake
module wb_excp_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  input  logic [31:0] ms_pc,
  input  logic [4:0]  ms_excp,
  input  logic [31:0] ms_bad_addr,
  input  logic [1:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wdata,
  input  logic [31:0] ms_csr_mask,
  input  logic        ms_ertn,
  input  logic        ms_rf_we,
  input  logic [4:0]  ms_rf_waddr,
  input  logic [31:0] ms_result,
  output logic        ws_allowin,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [13:0] rd_addr,
  input  logic [31:0] rd_data,
  input  logic        has_int,
  input  logic [31:0] eentry_out,
  input  logic [31:0] era_out,
  output logic        csr_wr_en,
  output logic [13:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [31:0] era_in,
  output logic [5:0]  ecode_in,
  output logic [8:0]  esubcode_in,
  output logic [31:0] bad_va_in,
  output logic        va_error_in,
  output logic        redirect_valid,
  output logic [31:0] redirect_target,
  input  logic        redirect_ready
);

  typedef enum logic {RUN, REDIR} state_e;

  localparam logic [1:0] CSR_NONE = 2'd0;
  localparam logic [1:0] CSR_RD   = 2'd1;
  localparam logic [1:0] CSR_WR   = 2'd2;
  localparam logic [1:0] CSR_XCHG = 2'd3;

  state_e      state_q, state_d;
  logic        ws_valid_q, ws_valid_d;
  logic [31:0] ws_pc_q, ws_pc_d;
  logic [4:0]  ws_excp_q, ws_excp_d;
  logic [31:0] ws_bad_addr_q, ws_bad_addr_d;
  logic [1:0]  ws_csr_op_q, ws_csr_op_d;
  logic [13:0] ws_csr_num_q, ws_csr_num_d;
  logic [31:0] ws_csr_wdata_q, ws_csr_wdata_d;
  logic [31:0] ws_csr_mask_q, ws_csr_mask_d;
  logic        ws_ertn_q, ws_ertn_d;
  logic        ws_rf_we_q, ws_rf_we_d;
  logic [4:0]  ws_rf_waddr_q, ws_rf_waddr_d;
  logic [31:0] ws_result_q, ws_result_d;
  logic [31:0] target_q, target_d;

  logic commit;
  logic excp_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      ws_valid_q     <= 1'b0;
      ws_pc_q        <= '0;
      ws_excp_q      <= '0;
      ws_bad_addr_q  <= '0;
      ws_csr_op_q    <= '0;
      ws_csr_num_q   <= '0;
      ws_csr_wdata_q <= '0;
      ws_csr_mask_q  <= '0;
      ws_ertn_q      <= 1'b0;
      ws_rf_we_q     <= 1'b0;
      ws_rf_waddr_q  <= '0;
      ws_result_q    <= '0;
      target_q       <= '0;
    end else begin
      state_q        <= state_d;
      ws_valid_q     <= ws_valid_d;
      ws_pc_q        <= ws_pc_d;
      ws_excp_q      <= ws_excp_d;
      ws_bad_addr_q  <= ws_bad_addr_d;
      ws_csr_op_q    <= ws_csr_op_d;
      ws_csr_num_q   <= ws_csr_num_d;
      ws_csr_wdata_q <= ws_csr_wdata_d;
      ws_csr_mask_q  <= ws_csr_mask_d;
      ws_ertn_q      <= ws_ertn_d;
      ws_rf_we_q     <= ws_rf_we_d;
      ws_rf_waddr_q  <= ws_rf_waddr_d;
      ws_result_q    <= ws_result_d;
      target_q       <= target_d;
    end
  end

  // has_int is only meaningful while a valid instruction commits in RUN.
  assign commit   = ws_valid_q && (state_q == RUN);
  assign excp_any = commit && (has_int || (ws_excp_q != 5'd0));

  always_comb begin
    state_d        = state_q;
    ws_valid_d     = ws_valid_q;
    ws_pc_d        = ws_pc_q;
    ws_excp_d      = ws_excp_q;
    ws_bad_addr_d  = ws_bad_addr_q;
    ws_csr_op_d    = ws_csr_op_q;
    ws_csr_num_d   = ws_csr_num_q;
    ws_csr_wdata_d = ws_csr_wdata_q;
    ws_csr_mask_d  = ws_csr_mask_q;
    ws_ertn_d      = ws_ertn_q;
    ws_rf_we_d     = ws_rf_we_q;
    ws_rf_waddr_d  = ws_rf_waddr_q;
    ws_result_d    = ws_result_q;
    target_d       = target_q;

    ws_allowin      = (state_q == RUN);
    rf_we           = 1'b0;
    rf_waddr        = '0;
    rf_wdata        = '0;
    rd_addr         = '0;
    csr_wr_en       = 1'b0;
    wr_addr         = '0;
    wr_data         = '0;
    excp_flush      = 1'b0;
    ertn_flush      = 1'b0;
    era_in          = '0;
    ecode_in        = '0;
    esubcode_in     = '0;
    bad_va_in       = '0;
    va_error_in     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;

    if (ws_allowin) begin
      ws_valid_d     = ms_to_ws_valid;
      ws_pc_d        = ms_pc;
      ws_excp_d      = ms_excp;
      ws_bad_addr_d  = ms_bad_addr;
      ws_csr_op_d    = ms_csr_op;
      ws_csr_num_d   = ms_csr_num;
      ws_csr_wdata_d = ms_csr_wdata;
      ws_csr_mask_d  = ms_csr_mask;
      ws_ertn_d      = ms_ertn;
      ws_rf_we_d     = ms_rf_we;
      ws_rf_waddr_d  = ms_rf_waddr;
      ws_result_d    = ms_result;
    end

    case (state_q)
      RUN: begin
        if (excp_any) begin
          excp_flush = 1'b1;
          era_in     = ws_pc_q;
          // ms_excp bit order is {ale, brk, sys, ine, adef}
          if (has_int) begin
            ecode_in = 6'h00;
          end else if (ws_excp_q[0]) begin
            ecode_in    = 6'h08;
            va_error_in = 1'b1;
            bad_va_in   = ws_pc_q;
          end else if (ws_excp_q[1]) begin
            ecode_in = 6'h0D;
          end else if (ws_excp_q[2]) begin
            ecode_in = 6'h0B;
          end else if (ws_excp_q[3]) begin
            ecode_in = 6'h0C;
          end else begin
            ecode_in    = 6'h09;
            va_error_in = 1'b1;
            bad_va_in   = ws_bad_addr_q;
          end
          target_d   = eentry_out;
          ws_valid_d = 1'b0;
          state_d    = REDIR;
        end else if (commit && ws_ertn_q) begin
          ertn_flush = 1'b1;
          target_d   = era_out;
          ws_valid_d = 1'b0;
          state_d    = REDIR;
        end else if (commit) begin
          rd_addr = ws_csr_num_q;
          if (ws_csr_op_q != CSR_NONE) begin
            rf_we    = 1'b1;
            rf_waddr = ws_rf_waddr_q;
            rf_wdata = rd_data;
          end else begin
            rf_we    = ws_rf_we_q;
            rf_waddr = ws_rf_waddr_q;
            rf_wdata = ws_result_q;
          end
          if (ws_csr_op_q == CSR_WR) begin
            csr_wr_en = 1'b1;
            wr_addr   = ws_csr_num_q;
            wr_data   = ws_csr_wdata_q;
          end else if (ws_csr_op_q == CSR_XCHG) begin
            csr_wr_en = 1'b1;
            wr_addr   = ws_csr_num_q;
            wr_data   = (ws_csr_wdata_q & ws_csr_mask_q) | (rd_data & ~ws_csr_mask_q);
          end
        end
      end
      REDIR: begin
        redirect_valid  = 1'b1;
        redirect_target = target_q;
        if (redirect_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_wb_excp_ctrl.sv
module tb_wb_excp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [4:0]  ms_excp;
  logic [31:0] ms_bad_addr;
  logic [1:0]  ms_csr_op;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wdata;
  logic [31:0] ms_csr_mask;
  logic        ms_ertn;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_result;
  logic        ws_allowin;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [13:0] rd_addr;
  logic [31:0] rd_data;
  logic        has_int;
  logic [31:0] eentry_out;
  logic [31:0] era_out;
  logic        csr_wr_en;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;
  logic        excp_flush;
  logic        ertn_flush;
  logic [31:0] era_in;
  logic [5:0]  ecode_in;
  logic [8:0]  esubcode_in;
  logic [31:0] bad_va_in;
  logic        va_error_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        redirect_ready;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  wb_excp_ctrl dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_excp(ms_excp),
    .ms_bad_addr(ms_bad_addr), .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num),
    .ms_csr_wdata(ms_csr_wdata), .ms_csr_mask(ms_csr_mask), .ms_ertn(ms_ertn),
    .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_result(ms_result),
    .ws_allowin(ws_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .has_int(has_int),
    .eentry_out(eentry_out), .era_out(era_out),
    .csr_wr_en(csr_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .era_in(era_in),
    .ecode_in(ecode_in), .esubcode_in(esubcode_in), .bad_va_in(bad_va_in),
    .va_error_in(va_error_in), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .redirect_ready(redirect_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_ms();
    ms_to_ws_valid = 1'b0; ms_pc = '0; ms_excp = '0; ms_bad_addr = '0;
    ms_csr_op = '0; ms_csr_num = '0; ms_csr_wdata = '0; ms_csr_mask = '0;
    ms_ertn = 1'b0; ms_rf_we = 1'b0; ms_rf_waddr = '0; ms_result = '0;
  endtask

  // Present the current ms_* fields for one edge, then leave the WB register
  // holding that instruction with the MEM stage empty.
  task automatic issue();
    ms_to_ws_valid = 1'b1;
    @(posedge clk); #1;
    clear_ms();
    #1;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  initial begin
    reset = 1'b1; rd_data = '0; has_int = 1'b0; eentry_out = '0;
    era_out = '0; redirect_ready = 1'b0;
    clear_ms();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_allowin", ws_allowin, 1);
    check_eq("rst_rvalid", redirect_valid, 0);
    check_eq("rst_excp", excp_flush, 0);
    check_eq("rst_ertn", ertn_flush, 0);
    check_eq("rst_rf_we", rf_we, 0);

    // empty WB with a pending interrupt raises nothing
    has_int = 1'b1; #1;
    check_eq("idle_int_noflush", excp_flush, 0);
    has_int = 1'b0;

    // csrxchg
    ms_csr_op = 2'd3; ms_csr_num = 14'h30; ms_csr_wdata = 32'h12345678;
    ms_csr_mask = 32'h0000FFFF; ms_rf_waddr = 5'd5;
    issue();
    rd_data = 32'hFFFF0000; #1;
    check_eq("xchg_rd_addr", rd_addr, 32'h30);
    check_eq("xchg_wr_en", csr_wr_en, 1);
    check_eq("xchg_wr_addr", wr_addr, 32'h30);
    check_eq("xchg_wr_data", wr_data, 32'hFFFF5678);
    check_eq("xchg_rf_we", rf_we, 1);
    check_eq("xchg_rf_waddr", rf_waddr, 5);
    check_eq("xchg_rf_wdata", rf_wdata, 32'hFFFF0000);

    // csrwr follows back-to-back
    ms_csr_op = 2'd2; ms_csr_num = 14'h6; ms_csr_wdata = 32'hA5A5A5A5; ms_rf_waddr = 5'd7;
    issue();
    rd_data = 32'h00000011; #1;
    check_eq("wr_wr_en", csr_wr_en, 1);
    check_eq("wr_wr_data", wr_data, 32'hA5A5A5A5);
    check_eq("wr_rf_wdata", rf_wdata, 32'h00000011);

    // csrrd: no CSR write
    ms_csr_op = 2'd1; ms_csr_num = 14'h1; ms_rf_waddr = 5'd9;
    issue();
    rd_data = 32'h0000BEEF; #1;
    check_eq("rd_wr_en", csr_wr_en, 0);
    check_eq("rd_rf_wdata", rf_wdata, 32'h0000BEEF);

    // plain ALU writeback
    ms_rf_we = 1'b1; ms_rf_waddr = 5'd3; ms_result = 32'hDEADBEEF;
    issue();
    check_eq("alu_rf_we", rf_we, 1);
    check_eq("alu_rf_waddr", rf_waddr, 3);
    check_eq("alu_rf_wdata", rf_wdata, 32'hDEADBEEF);
    check_eq("alu_wr_en", csr_wr_en, 0);
    step();
    check_eq("idle_rf_we", rf_we, 0);
    check_eq("idle_wr_en", csr_wr_en, 0);

    // syscall
    eentry_out = 32'h1C008000;
    ms_pc = 32'h1C000100; ms_excp = 5'b00100; ms_rf_we = 1'b1; ms_rf_waddr = 5'd4;
    issue();
    check_eq("sys_flush", excp_flush, 1);
    check_eq("sys_ertn", ertn_flush, 0);
    check_eq("sys_ecode", ecode_in, 32'h0B);
    check_eq("sys_esub", esubcode_in, 0);
    check_eq("sys_era", era_in, 32'h1C000100);
    check_eq("sys_vaerr", va_error_in, 0);
    check_eq("sys_rf_we", rf_we, 0);
    check_eq("sys_rvalid0", redirect_valid, 0);
    step();
    eentry_out = 32'h0; has_int = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("sys_hold_rvalid", redirect_valid, 1);
      check_eq("sys_hold_target", redirect_target, 32'h1C008000);
      check_eq("sys_hold_allowin", ws_allowin, 0);
      check_eq("sys_hold_noflush", excp_flush, 0);
      if (i < 2) step();
    end
    has_int = 1'b0;
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0; #1;
    check_eq("sys_back_rvalid", redirect_valid, 0);
    check_eq("sys_back_allowin", ws_allowin, 1);
    check_eq("sys_back_payload", era_in, 0);

    // ALE with simultaneous interrupt: interrupt wins
    eentry_out = 32'h1C009000;
    ms_pc = 32'h1C000300; ms_excp = 5'b10000; ms_bad_addr = 32'h1003;
    issue();
    has_int = 1'b1; #1;
    check_eq("int_flush", excp_flush, 1);
    check_eq("int_ecode", ecode_in, 0);
    check_eq("int_vaerr", va_error_in, 0);
    check_eq("int_badva", bad_va_in, 0);
    redirect_ready = 1'b1;
    step();
    has_int = 1'b0; #1;
    check_eq("int_rvalid", redirect_valid, 1);
    check_eq("int_target", redirect_target, 32'h1C009000);
    step();
    redirect_ready = 1'b0; #1;
    check_eq("int_back_allowin", ws_allowin, 1);

    // plain ALE
    ms_pc = 32'h1C000304; ms_excp = 5'b10000; ms_bad_addr = 32'h2007;
    issue();
    check_eq("ale_ecode", ecode_in, 32'h09);
    check_eq("ale_vaerr", va_error_in, 1);
    check_eq("ale_badva", bad_va_in, 32'h2007);
    redirect_ready = 1'b1;
    repeat (2) step();
    redirect_ready = 1'b0;

    // ine and sys together: ine wins
    ms_pc = 32'h1C000400; ms_excp = 5'b01110;
    issue();
    check_eq("ine_ecode", ecode_in, 32'h0D);
    redirect_ready = 1'b1;
    repeat (2) step();
    redirect_ready = 1'b0;

    // ADEF
    ms_pc = 32'h1C000002; ms_excp = 5'b10001; ms_bad_addr = 32'h55; ms_rf_we = 1'b1;
    ms_rf_waddr = 5'd8;
    issue();
    check_eq("adef_flush", excp_flush, 1);
    check_eq("adef_ecode", ecode_in, 32'h08);
    check_eq("adef_badva", bad_va_in, 32'h1C000002);
    check_eq("adef_vaerr", va_error_in, 1);
    check_eq("adef_rf_we", rf_we, 0);
    redirect_ready = 1'b1;
    repeat (2) step();
    redirect_ready = 1'b0;

    // ertn, then reset during REDIR
    era_out = 32'h1C000200;
    ms_pc = 32'h1C000500; ms_ertn = 1'b1;
    issue();
    check_eq("ertn_flush", ertn_flush, 1);
    check_eq("ertn_excp", excp_flush, 0);
    check_eq("ertn_rf_we", rf_we, 0);
    check_eq("ertn_wr_en", csr_wr_en, 0);
    check_eq("ertn_era_in", era_in, 0);
    step();
    check_eq("ertn_rvalid", redirect_valid, 1);
    check_eq("ertn_target", redirect_target, 32'h1C000200);
    reset = 1'b1;
    step();
    reset = 1'b0; #1;
    check_eq("rst_redir_rvalid", redirect_valid, 0);
    check_eq("rst_redir_allowin", ws_allowin, 1);
    check_eq("rst_redir_target", redirect_target, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
